// File: rtl/game_ctrl.sv
// Game sequencer: mode FSM, frame tick, N_OBS-cycle collision scan and score counter.
// Switches reach gamemode on the 3rd edge; a hit scan ends the game N_OBS+1 cycles after its tick.
module game_ctrl #(
  parameter int TICK_DIV    = 833333,
  parameter int PLAYER_X    = 100,
  parameter int PLAYER_SIZE = 40,
  parameter int N_OBS       = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           sw,
  input  logic [8:0]           player_y,
  input  logic [20*N_OBS-1:0]  obstacle_x,
  input  logic [18*N_OBS-1:0]  obstacle_y,
  output logic [1:0]           gamemode,
  output logic                 frame_tick,
  output logic                 crash,
  output logic                 scan_busy,
  output logic [15:0]          score
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = (N_OBS > 1) ? $clog2(N_OBS) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_OBS - 1);
  localparam logic [9:0]    PX_L      = 10'(PLAYER_X);
  localparam logic [9:0]    PX_R      = 10'(PLAYER_X + PLAYER_SIZE);
  localparam logic [9:0]    PSZ       = 10'(PLAYER_SIZE);

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_END   = 2'b11
  } state_t;

  state_t        state, state_nx;
  logic [2:1]    sw_meta, sw_sync;
  logic [CW-1:0] tick_cnt;
  logic [IW-1:0] scan_idx;
  logic          hit;
  logic [8:0]    py;
  logic          unused_sw;

  assign unused_sw = sw[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw[2:1];
      sw_sync <= sw_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    tick_cnt <= '0;
    else if (tick_cnt == TICK_LAST) tick_cnt <= '0;
    else                           tick_cnt <= tick_cnt + CW'(1);
  end

  assign frame_tick = (tick_cnt == TICK_LAST);

  // Slot currently addressed by the scan, unpacked from the flat buses.
  logic [19:0] slot_x [N_OBS];
  logic [17:0] slot_y [N_OBS];

  always_comb begin
    for (int i = 0; i < N_OBS; i++) begin
      slot_x[i] = obstacle_x[20*i +: 20];
      slot_y[i] = obstacle_y[18*i +: 18];
    end
  end

  logic [9:0] cur_l, cur_r, cur_t, cur_b, py_top, py_bot;
  logic       slot_valid, overlap, last_slot, scan_hit_done, scan_start;

  assign cur_l  = slot_x[scan_idx][19:10];
  assign cur_r  = slot_x[scan_idx][9:0];
  assign cur_t  = {1'b0, slot_y[scan_idx][17:9]};
  assign cur_b  = {1'b0, slot_y[scan_idx][8:0]};
  assign py_top = {1'b0, py};
  assign py_bot = py_top + PSZ;

  // Strict compares: boxes that only touch on an edge do not collide.
  assign slot_valid    = (cur_l < cur_r) && (cur_t < cur_b);
  assign overlap       = slot_valid && (PX_L < cur_r) && (PX_R > cur_l) &&
                         (py_top < cur_b) && (py_bot > cur_t);
  assign last_slot     = scan_busy && (scan_idx == IDX_LAST);
  assign scan_hit_done = last_slot && (hit || overlap);
  assign scan_start    = frame_tick && (state == ST_RUN) && !scan_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_INIT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_INIT:  if (sw_sync[2]) state_nx = ST_RUN;
      ST_RUN: begin
        if (!sw_sync[2])        state_nx = ST_INIT;
        else if (scan_hit_done) state_nx = ST_END;
        else if (sw_sync[1])    state_nx = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (!sw_sync[2])        state_nx = ST_INIT;
        else if (!sw_sync[1])   state_nx = ST_RUN;
      end
      ST_END:   if (!sw_sync[2]) state_nx = ST_INIT;
      default:  state_nx = ST_INIT;
    endcase
  end

  always_comb begin
    gamemode = state;
  end

  // Any departure from RUN (pause, stop, or the crash itself) tears the scan down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_busy <= 1'b0;
      scan_idx  <= '0;
      hit       <= 1'b0;
      py        <= '0;
    end else if (state_nx != ST_RUN) begin
      scan_busy <= 1'b0;
      scan_idx  <= '0;
      hit       <= 1'b0;
    end else if (scan_start) begin
      scan_busy <= 1'b1;
      scan_idx  <= '0;
      hit       <= 1'b0;
      py        <= player_y;
    end else if (scan_busy) begin
      if (last_slot) begin
        scan_busy <= 1'b0;
        scan_idx  <= '0;
        hit       <= 1'b0;
      end else begin
        scan_idx  <= scan_idx + IW'(1);
        hit       <= hit | overlap;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crash <= 1'b0;
    else        crash <= (state == ST_RUN) && (state_nx == ST_END);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      score <= '0;
    else if (state == ST_INIT && state_nx == ST_RUN)
      score <= '0;
    else if (state == ST_RUN && frame_tick && score != 16'hFFFF)
      score <= score + 16'd1;
  end

endmodule
